// File: rtl/lamp_fract_sqrt_iter.sv
// Iterative Goldschmidt sqrt / inverse-sqrt on a pre-aligned mantissa, U2.(W-2) datapath, LUT seed.
// Latency 2*N_ITER-1 cycles from accept (1 with LAMP_SQRT_ONE_BYPASS_EN for X=1.0); ready_o only in IDLE, result held until ready_i.
module lamp_fract_sqrt_iter #(
    parameter int F_DW      = 7,
    parameter int PREC_DW   = 8,
    parameter int APPROX_DW = 4,
    parameter int N_ITER    = 3,
    parameter int ID_DW     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    op_i,
    input  logic [F_DW+1:0]         f_i,
    input  logic [ID_DW-1:0]        id_i,
    input  logic                    flush_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [2*(F_DW+1)-1:0]   result_o,
    output logic [ID_DW-1:0]        id_o,
    output logic                    range_err_o
);

    localparam int W      = F_DW + 2 + PREC_DW;
    localparam int RES_W  = 2 * (F_DW + 1);
    localparam int IDX_W  = APPROX_DW + 1;
    localparam int SEED_W = APPROX_DW + 2;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int SHIFT  = F_DW + 2 - IDX_W;

    // 1.5 in U2.(W-2), used for y = (3 - b) / 2
    localparam logic [W-1:0]      Y_THREE_HALF = W'(3) << (W - 3);
    localparam logic [RES_W-1:0]  RES_ONE      = RES_W'(1) << (RES_W - 1);
    localparam logic [F_DW+1:0]   F_ONE        = {2'b01, {F_DW{1'b0}}};

    // Largest U1.IDX_W seed e with e^2 * midpoint <= 1, saturating at the table width.
    function automatic logic [(2**IDX_W)*SEED_W-1:0] build_lut();
        logic [(2**IDX_W)*SEED_W-1:0] lut;
        longint mid;
        longint lim;
        int     best;
        lut = '0;
        lim = longint'(1) << (2 * IDX_W + F_DW + 1);
        for (int i = 0; i < 2**IDX_W; i++) begin
            mid  = (longint'(i) << SHIFT) + (longint'(1) << (SHIFT - 1));
            best = 0;
            for (int e = 0; e < 2**SEED_W; e++) begin
                if (longint'(e) * longint'(e) * mid <= lim) best = e;
            end
            lut[i*SEED_W +: SEED_W] = SEED_W'(best);
        end
        return lut;
    endfunction

    localparam logic [(2**IDX_W)*SEED_W-1:0] SEED_LUT = build_lut();

    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a * b;
        return p[W-2 +: W];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_UPD, S_DONE} state_t;

    state_t             state_q, state_n;
    logic [W-1:0]       b_q, y_q, r_q;
    logic [W-1:0]       by, b_mul, r_mul;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q, rng_q, byp_q;
    logic [ID_DW-1:0]   id_q;
    logic               accept, last, bypass_hit;
    logic [SEED_W-1:0]  seed;

    assign ready_o = (state_q == S_IDLE);
    assign accept  = valid_i && ready_o && !flush_i;
    assign seed    = SEED_LUT[f_i[F_DW+1 -: IDX_W]*SEED_W +: SEED_W];

`ifdef LAMP_SQRT_ONE_BYPASS_EN
    assign bypass_hit = (f_i == F_ONE);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        by      = fmul(b_q, y_q);
        b_mul   = fmul(by, y_q);
        r_mul   = (cnt_q == '0) ? (op_q ? y_q : by) : fmul(r_q, y_q);
        last    = (cnt_q == CNT_W'(N_ITER - 1));
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_n = S_MUL;
            S_MUL:   state_n = (byp_q || last) ? S_DONE : S_UPD;
            S_UPD:   state_n = S_MUL;
            S_DONE:  if (ready_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush_i) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            y_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            rng_q       <= 1'b0;
            byp_q       <= 1'b0;
            id_q        <= '0;
            valid_o     <= 1'b0;
            result_o    <= '0;
            id_o        <= '0;
            range_err_o <= 1'b0;
        end else begin
            state_q <= state_n;
            if (flush_i) begin
                valid_o <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (accept) begin
                        b_q   <= {1'b0, f_i, {(PREC_DW-1){1'b0}}};
                        y_q   <= {1'b0, seed, {(W-1-SEED_W){1'b0}}};
                        r_q   <= '0;
                        cnt_q <= '0;
                        op_q  <= op_i;
                        id_q  <= id_i;
                        rng_q <= (f_i[F_DW+1:F_DW] == 2'b00);
                        byp_q <= bypass_hit;
                    end
                    S_MUL: if (byp_q) begin
                        valid_o     <= 1'b1;
                        result_o    <= RES_ONE;
                        id_o        <= id_q;
                        range_err_o <= 1'b0;
                    end else begin
                        b_q <= b_mul;
                        r_q <= r_mul;
                        if (last) begin
                            valid_o     <= 1'b1;
                            result_o    <= rng_q ? '0 : r_mul[W-2 -: RES_W];
                            id_o        <= id_q;
                            range_err_o <= rng_q;
                        end
                    end
                    S_UPD: begin
                        y_q   <= Y_THREE_HALF - (b_q >> 1);
                        cnt_q <= cnt_q + 1'b1;
                    end
                    S_DONE: if (ready_i) valid_o <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
